// File: rtl/uart_cmd_ctrl.sv
// UART command controller: frames A5 OP A B CHK into an ALU launch,
// then returns the ALU result, with checksum, opcode and timeout errors.
module uart_cmd_ctrl #(
    parameter int CLK_FREQ      = 100_000_000,
    parameter int BAUD_RATE     = 9600,
    parameter int TIMEOUT_BYTES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    output logic [3:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic        alu_start,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
    output logic [15:0] result,
    output logic        result_valid,
    output logic        err_chk,
    output logic        err_op,
    output logic        err_timeout,
    output logic        busy
);
    localparam int TIMEOUT = TIMEOUT_BYTES * 10 * (CLK_FREQ / BAUD_RATE);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    localparam logic [7:0] SYNC = 8'hA5;

    typedef enum logic [1:0] {IDLE, COLLECT, CHECK, WAIT_ALU} state_t;

    state_t        state;
    state_t        state_next;
    logic [2:0]    idx;
    logic [CW-1:0] cnt;
    logic [7:0]    frame [6];

    logic chk_bad;
    logic op_bad;
    logic launch;
    logic take_byte;
    logic take_done;
    logic expired;
    logic tmo;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:     if (rx_done && rx_data == SYNC) state_next = COLLECT;
            COLLECT:  if (take_byte && idx == 3'd5)   state_next = CHECK;
                      else if (tmo)                   state_next = IDLE;
            CHECK:    if (launch)                     state_next = WAIT_ALU;
                      else                            state_next = IDLE;
            WAIT_ALU: if (take_done || tmo)           state_next = IDLE;
            default:                                  state_next = IDLE;
        endcase
    end

    // A byte or ALU completion on the expiry cycle wins over the timeout.
    always_comb begin
        chk_bad   = (frame[0] ^ frame[1] ^ frame[2] ^ frame[3] ^ frame[4])
                    != frame[5];
        op_bad    = frame[0][7:4] != 4'h0;
        launch    = state == CHECK && !chk_bad && !op_bad;
        take_byte = state == COLLECT && rx_done;
        take_done = state == WAIT_ALU && alu_done && !alu_start;
        expired   = cnt == LAST;
        tmo       = expired &&
                    ((state == COLLECT && !rx_done) ||
                     (state == WAIT_ALU && !take_done));
    end

    assign busy = state != IDLE;

    always_ff @(posedge clk) begin
        if (take_byte) frame[idx] <= rx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx          <= '0;
            cnt          <= '0;
            alu_op       <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_start    <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            err_chk      <= 1'b0;
            err_op       <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            alu_start    <= launch;
            err_chk      <= state == CHECK && chk_bad;
            err_op       <= state == CHECK && !chk_bad && op_bad;
            err_timeout  <= tmo;
            result_valid <= take_done;
            if (launch) begin
                alu_op <= frame[0][3:0];
                alu_a  <= {frame[1], frame[2]};
                alu_b  <= {frame[3], frame[4]};
            end
            if (take_done) result <= alu_result;
            if (take_byte)          idx <= idx + 3'd1;
            else if (state == IDLE) idx <= '0;
            if (state_next != state || take_byte)
                cnt <= '0;
            else if (state == COLLECT || state == WAIT_ALU)
                cnt <= cnt + 1'b1;
        end
    end
endmodule
